uart_byte_rx: RTL and testbench

UART receiver stage feeding the display path: it deserialises the raw uart_rx pin into bytes for the downstream command/pixel writer. 8 data bits, LSB first, 1 stop bit, no flow control. Runs in the 40 MHz pixel-clock domain. It synchronises the asynchronous pin, validates the start bit, and reports framing errors.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_byte_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // 40 MHz pixel clock / 115200 baud.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 347;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for asynchronous inputs.
// RESET_VAL sets the value both flops take during reset, so an idle-high
// line does not look like an edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8 data bits, LSB first, 1 stop bit.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN;
// without it there is no parity bit on the line and parity_err_o is tied 0.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      frame_err_o,
  output logic                      parity_err_o,
  output logic                      busy_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  // Below 4 clocks per bit the half-bit offset degenerates.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic                      rx_s;
  rx_state_t                 state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shift, shift_nxt;
  logic [UART_DATA_BITS-1:0] data_nxt;
  logic                      valid_nxt;
  logic                      frame_nxt;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit, par_bit_nxt;
  logic                      parity_err_nxt;
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d    (uart_rx),
    .q    (rx_s)
  );

  assign busy_o = (state != IDLE);

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      data_o      <= data_nxt;
      valid_o     <= valid_nxt;
      frame_err_o <= frame_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit and its registered error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      par_bit      <= par_bit_nxt;
      parity_err_o <= parity_err_nxt;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

  // Next-state logic; the bit counter restarts on every state change.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = data_o;
    valid_nxt   = 1'b0;
    frame_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt    = par_bit;
    parity_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_s, shift[UART_DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          par_bit_nxt = rx_s;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par_bit}) begin
              parity_err_nxt = 1'b1;
            end else begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end
`else
            data_nxt  = shift;
            valid_nxt = 1'b1;
`endif
          end else begin
            frame_nxt = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise parity.
module tb_uart_byte_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_CYCLES = (10 + PAR_BITS) * CPB;
  // Cycle count from the negedge that drives the start bit low to the
  // negedge that sees valid_o: one cycle to the registering edge, then
  // 2 + HALF + 9*CPB + 1 (+ CPB for parity), with +/-1 tolerance.
  localparam int EXP_LAT = 1 + 2 + HALF + (9 + PAR_BITS) * CPB + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       busy_o;

  int vectors = 0;
  int miscompares = 0;

  int cycle = 0;
  int start_cycle = 0;
  int valid_count = 0;
  int frame_count = 0;
  int parity_count = 0;
  int last_valid_cycle = 0;
  int prev_valid_cycle = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic [7:0] prev_valid_data = 8'h00;
  logic both_seen = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic force_bad_parity = 1'b0;
`endif

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter for latency and spacing measurements.
  always @(posedge clock) cycle <= cycle + 1;

  // Record every output pulse away from the active edge.
  always @(negedge clock) begin
    if (valid_o) begin
      valid_count      = valid_count + 1;
      prev_valid_cycle = last_valid_cycle;
      last_valid_cycle = cycle;
      prev_valid_data  = last_valid_data;
      last_valid_data  = data_o;
    end
    if (frame_err_o) frame_count = frame_count + 1;
    if (parity_err_o) parity_count = parity_count + 1;
    if (valid_o && frame_err_o) both_seen = 1'b1;
  end

  // Drive one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    start_cycle = cycle;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ force_bad_parity;
    repeat (CPB) @(negedge clock);
`endif
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++; if (data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data got %h want 00", data_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid_o); end
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame got %b want 0", frame_err_o); end
    vectors++; if (parity_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_parity got %b want 0", parity_err_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_busy got %b want 0", busy_o); end
  endtask

  task automatic test_single_byte();
    int v0, f0, p0, lat;
    v0 = valid_count; f0 = frame_count; p0 = parity_count;
    send_frame(8'hA5, 1'b1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    lat = last_valid_cycle - start_cycle;
    vectors++; if (valid_count !== v0 + 1) begin miscompares++; $display("[TB] FAIL a5_valid_count got %0d want %0d", valid_count - v0, 1); end
    vectors++; if (data_o !== 8'hA5) begin miscompares++; $display("[TB] FAIL a5_data got %h want a5", data_o); end
    vectors++; if (frame_count !== f0) begin miscompares++; $display("[TB] FAIL a5_frame got %0d want 0", frame_count - f0); end
    vectors++; if (parity_count !== p0) begin miscompares++; $display("[TB] FAIL a5_parity got %0d want 0", parity_count - p0); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL a5_busy got %b want 0", busy_o); end
    vectors++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin miscompares++; $display("[TB] FAIL a5_latency got %0d want %0d+/-1", lat, EXP_LAT); end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = valid_count; f0 = frame_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    uart_rx = 1'b1;
    repeat (20) @(negedge clock);
    vectors++; if (valid_count !== v0 + 2) begin miscompares++; $display("[TB] FAIL b2b_valid_count got %0d want 2", valid_count - v0); end
    vectors++; if (prev_valid_data !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_first_data got %h want 00", prev_valid_data); end
    vectors++; if (last_valid_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_second_data got %h want ff", last_valid_data); end
    vectors++; if (last_valid_cycle - prev_valid_cycle !== FRAME_CYCLES) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d want %0d", last_valid_cycle - prev_valid_cycle, FRAME_CYCLES); end
    vectors++; if (frame_count !== f0) begin miscompares++; $display("[TB] FAIL b2b_frame got %0d want 0", frame_count - f0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_count; f0 = frame_count;
    uart_rx = 1'b0;
    repeat (4) @(negedge clock);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL glitch_busy_during got %b want 1", busy_o); end
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_busy_after got %b want 0", busy_o); end
    vectors++; if (valid_count !== v0) begin miscompares++; $display("[TB] FAIL glitch_valid got %0d want 0", valid_count - v0); end
    vectors++; if (frame_count !== f0) begin miscompares++; $display("[TB] FAIL glitch_frame got %0d want 0", frame_count - f0); end
    vectors++; if (data_o !== 8'hFF) begin miscompares++; $display("[TB] FAIL glitch_data got %h want ff", data_o); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_count; f0 = frame_count;
    send_frame(8'h3C, 1'b0);
    repeat (50) @(negedge clock);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_busy_break got %b want 1", busy_o); end
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clock);
    vectors++; if (frame_count !== f0 + 1) begin miscompares++; $display("[TB] FAIL ferr_count got %0d want 1", frame_count - f0); end
    vectors++; if (valid_count !== v0) begin miscompares++; $display("[TB] FAIL ferr_valid got %0d want 0", valid_count - v0); end
    vectors++; if (data_o !== 8'hFF) begin miscompares++; $display("[TB] FAIL ferr_data got %h want ff", data_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_busy_idle got %b want 0", busy_o); end
    send_frame(8'h81, 1'b1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    vectors++; if (valid_count !== v0 + 1) begin miscompares++; $display("[TB] FAIL ferr_next_valid got %0d want 1", valid_count - v0); end
    vectors++; if (data_o !== 8'h81) begin miscompares++; $display("[TB] FAIL ferr_next_data got %h want 81", data_o); end
    vectors++; if (frame_count !== f0 + 1) begin miscompares++; $display("[TB] FAIL ferr_next_frame got %0d want 1", frame_count - f0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [7:0] aborted;
    aborted = 8'h96;
    v0 = valid_count; f0 = frame_count;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      uart_rx = aborted[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = aborted[4];
    repeat (HALF) @(negedge clock);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_busy_before got %b want 1", busy_o); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL rstmid_data got %h want 00", data_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy got %b want 0", busy_o); end
    uart_rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clock);
    vectors++; if (valid_count !== v0) begin miscompares++; $display("[TB] FAIL rstmid_valid got %0d want 0", valid_count - v0); end
    vectors++; if (frame_count !== f0) begin miscompares++; $display("[TB] FAIL rstmid_frame got %0d want 0", frame_count - f0); end
    send_frame(8'h5A, 1'b1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    vectors++; if (valid_count !== v0 + 1) begin miscompares++; $display("[TB] FAIL rstmid_5a_valid got %0d want 1", valid_count - v0); end
    vectors++; if (data_o !== 8'h5A) begin miscompares++; $display("[TB] FAIL rstmid_5a_data got %h want 5a", data_o); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int v0, p0, f0;
    v0 = valid_count; p0 = parity_count; f0 = frame_count;
    force_bad_parity = 1'b1;
    send_frame(8'h07, 1'b1);
    force_bad_parity = 1'b0;
    uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    vectors++; if (parity_count !== p0 + 1) begin miscompares++; $display("[TB] FAIL par_bad_count got %0d want 1", parity_count - p0); end
    vectors++; if (valid_count !== v0) begin miscompares++; $display("[TB] FAIL par_bad_valid got %0d want 0", valid_count - v0); end
    vectors++; if (data_o !== 8'h5A) begin miscompares++; $display("[TB] FAIL par_bad_data got %h want 5a", data_o); end
    vectors++; if (frame_count !== f0) begin miscompares++; $display("[TB] FAIL par_bad_frame got %0d want 0", frame_count - f0); end
    send_frame(8'h07, 1'b1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clock);
    vectors++; if (valid_count !== v0 + 1) begin miscompares++; $display("[TB] FAIL par_good_valid got %0d want 1", valid_count - v0); end
    vectors++; if (data_o !== 8'h07) begin miscompares++; $display("[TB] FAIL par_good_data got %h want 07", data_o); end
    vectors++; if (parity_count !== p0 + 1) begin miscompares++; $display("[TB] FAIL par_good_count got %0d want 1", parity_count - p0); end
`else
    vectors++; if (parity_count !== 0) begin miscompares++; $display("[TB] FAIL par_tied_count got %0d want 0", parity_count); end
    vectors++; if (parity_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL par_tied_level got %b want 0", parity_err_o); end
`endif
  endtask

  initial begin
    $display("[TB] uart_byte_rx bench, CLKS_PER_BIT=%0d", CPB);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_parity();
    vectors++; if (both_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL valid_and_frame_together got %b want 0", both_seen); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
